// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared widths, state encoding and token layout for the RLE codec
package rle_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
    localparam int TOK_W  = 16;

    localparam logic [CNT_W-1:0] MAX_CNT = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    // Token layout shared with the decoder: {eof, eor, count, value}
    typedef struct packed {
        logic              eof;
        logic              eor;
        logic [CNT_W-1:0]  count;
        logic [DATA_W-1:0] value;
    } tok_t;

    function automatic tok_t make_tok(input logic eof, input logic eor,
                                      input logic [CNT_W-1:0] count,
                                      input logic [DATA_W-1:0] value);
        tok_t t;
        t.eof   = eof;
        t.eor   = eor;
        t.count = count;
        t.value = value;
        return t;
    endfunction

endpackage

// File: rtl/rle_encoder_if.sv
// rtl/rle_encoder_if.sv - pixel input and token output handshake bundle
interface rle_encoder_if
    import rle_pkg::*;
;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_eor;
    logic              in_eof;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic [DATA_W-1:0] out_value;
    logic              out_eor;
    logic              out_eof;

    modport slave (
        input  in_valid, in_data, in_eor, in_eof, out_ready,
        output in_ready, out_valid, out_count, out_value, out_eor, out_eof
    );

    modport master (
        output in_valid, in_data, in_eor, in_eof, out_ready,
        input  in_ready, out_valid, out_count, out_value, out_eor, out_eof
    );
endinterface

// File: rtl/rle_tok_slot.sv
// rtl/rle_tok_slot.sv - single-entry registered token slot with valid/ready hold
module rle_tok_slot #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         free_o
);
    logic         valid_q;
    logic [W-1:0] data_q;

    // Slot can take a new token when empty or when its token leaves this cycle
    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Load wins over drain; contents held while stalled, kept after transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/rle_encoder.sv
// rtl/rle_encoder.sv - single-plane run-length encoder emitting (count, value) tokens
module rle_encoder
    import rle_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    rle_encoder_if.slave     bus,
    output logic             done,
    output logic [TOK_W-1:0] tok_cnt
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] cur_val_q, cur_val_d;
    logic [CNT_W-1:0]  cur_cnt_q, cur_cnt_d;
    tok_t              pend_q, pend_d;
    logic [TOK_W-1:0]  tok_cnt_q;

    logic slot_load, slot_valid, slot_free;
    tok_t slot_in, slot_out;
    logic accept, row_end, extend;

    assign bus.in_ready = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && slot_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign row_end      = bus.in_eor || bus.in_eof;
    assign extend       = (bus.in_data == cur_val_q) && (cur_cnt_q != MAX_CNT);

    rle_tok_slot #(.W($bits(tok_t))) u_slot (
        .clk     (clk),
        .rst_n   (rst),
        .load_i  (slot_load),
        .data_i  (slot_in),
        .ready_i (bus.out_ready),
        .valid_o (slot_valid),
        .data_o  (slot_out),
        .free_o  (slot_free)
    );

    assign bus.out_valid = slot_valid;
    assign bus.out_count = slot_out.count;
    assign bus.out_value = slot_out.value;
    assign bus.out_eor   = slot_out.eor;
    assign bus.out_eof   = slot_out.eof;
    assign done          = (state_q == ST_DONE) && !slot_valid;
    assign tok_cnt       = tok_cnt_q;

    // State, open run and pending second token
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cur_val_q <= '0;
            cur_cnt_q <= '0;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            cur_val_q <= cur_val_d;
            cur_cnt_q <= cur_cnt_d;
            pend_q    <= pend_d;
        end
    end

    // Run tracking: extend, close into the slot, or split at row end via FLUSH
    always_comb begin
        state_d   = state_q;
        cur_val_d = cur_val_q;
        cur_cnt_d = cur_cnt_q;
        pend_d    = pend_q;
        slot_load = 1'b0;
        slot_in   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!row_end) begin
                        cur_val_d = bus.in_data;
                        cur_cnt_d = CNT_W'(1);
                        state_d   = ST_RUN;
                    end else begin
                        slot_load = 1'b1;
                        slot_in   = make_tok(bus.in_eof, 1'b1, CNT_W'(1), bus.in_data);
                        state_d   = bus.in_eof ? ST_DONE : ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (extend && !row_end) begin
                        cur_cnt_d = cur_cnt_q + 1'b1;
                    end else if (extend) begin
                        slot_load = 1'b1;
                        slot_in   = make_tok(bus.in_eof, 1'b1, cur_cnt_q + 1'b1, cur_val_q);
                        state_d   = bus.in_eof ? ST_DONE : ST_IDLE;
                    end else begin
                        slot_load = 1'b1;
                        slot_in   = make_tok(1'b0, 1'b0, cur_cnt_q, cur_val_q);
                        if (!row_end) begin
                            cur_val_d = bus.in_data;
                            cur_cnt_d = CNT_W'(1);
                        end else begin
                            pend_d  = make_tok(bus.in_eof, 1'b1, CNT_W'(1), bus.in_data);
                            state_d = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (slot_free) begin
                    slot_load = 1'b1;
                    slot_in   = pend_q;
                    state_d   = pend_q.eof ? ST_DONE : ST_IDLE;
                end
            end
            default: begin
            end
        endcase
    end

    // Saturating count of tokens taken downstream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tok_cnt_q <= '0;
        end else if (slot_valid && bus.out_ready && (tok_cnt_q != '1)) begin
            tok_cnt_q <= tok_cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_rle_encoder.sv
// tb/tb_rle_encoder.sv - scoreboard bench for rle_encoder
module tb_rle_encoder;
    import rle_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             done;
    logic [TOK_W-1:0] tok_cnt;

    rle_encoder_if bus();

    rle_encoder dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .done    (done),
        .tok_cnt (tok_cnt)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    tok_t       exp_q[$];
    int         exp_tok = 0;
    int         rdy_mode = 0;
    logic [7:0] row_buf[0:511];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Downstream ready: 0 = always, 1 = random, 2 = held low
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops expected tokens on each transfer and checks stall stability
    initial begin : monitor
        bit   prev_stall = 0;
        tok_t prev_tok;
        tok_t cur;
        tok_t want;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 0;
            end else begin
                cur = make_tok(bus.out_eof, bus.out_eor, bus.out_count, bus.out_value);
                if (prev_stall)
                    check("stall_hold", {13'd0, bus.out_valid, cur}, {13'd0, 1'b1, prev_tok});
                if (bus.out_valid && bus.out_ready) begin
                    check("count_nonzero", 32'(bus.out_count != 0), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_token", 32'(cur), 32'hFFFFFFFF);
                    end else begin
                        want = exp_q.pop_front();
                        check("token", 32'(cur), 32'(want));
                    end
                    prev_stall = 0;
                end else if (bus.out_valid) begin
                    prev_stall = 1;
                    prev_tok   = cur;
                end else begin
                    prev_stall = 0;
                end
            end
        end
    end

    // Reference: maximal equal runs within the row, chopped at 255
    task automatic model_row(input int len, input bit last);
        int   i;
        int   j;
        tok_t t;
        i = 0;
        while (i < len) begin
            j = i;
            while (j < len && row_buf[j] == row_buf[i] && (j - i) < 255) j++;
            t = make_tok(last && (j == len), j == len, CNT_W'(j - i), row_buf[i]);
            exp_q.push_back(t);
            exp_tok++;
            i = j;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the pixel was accepted
    task automatic send_pixel(input logic [7:0] d, input bit eor, input bit eof, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_eor   = eor;
        bus.in_eof   = eof;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 2000) begin
                check("in_ready_timeout", 32'd0, 32'd1);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_row(input int len, input bit last, input bit gaps);
        model_row(len, last);
        for (int i = 0; i < len; i++)
            send_pixel(row_buf[i], i == len - 1, last && (i == len - 1), gaps);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 5000), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_q.delete();
        exp_tok = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_eor   = 1'b0;
        bus.in_eof   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_fields", {13'd0, bus.out_eof, bus.out_eor, bus.out_count, bus.out_value}, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tok_cnt", 32'(tok_cnt), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Mixed runs in one row
        row_buf[0] = 5; row_buf[1] = 5; row_buf[2] = 5;
        row_buf[3] = 7; row_buf[4] = 7; row_buf[5] = 9;
        send_row(6, 0, 0);
        drain();
        check("tok_cnt_row1", 32'(tok_cnt), 32'(exp_tok));

        // Equal rows must not merge across the boundary
        row_buf[0] = 8; row_buf[1] = 8;
        send_row(2, 0, 0);
        send_row(2, 0, 0);
        drain();
        check("tok_cnt_rows8", 32'(tok_cnt), 32'(exp_tok));

        // Split at row end while downstream stalls
        rdy_mode = 2;
        row_buf[0] = 1; row_buf[1] = 2;
        model_row(2, 0);
        send_pixel(8'd1, 0, 0, 0);
        send_pixel(8'd2, 1, 0, 0);
        row_buf[0] = 3;
        model_row(1, 1);
        fork
            send_pixel(8'd3, 1, 1, 0);
        join_none
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        rdy_mode = 0;
        wait fork;
        drain();
        check("stall_done", 32'(done), 32'd1);
        check("stall_in_ready_after", 32'(bus.in_ready), 32'd0);
        check("stall_tok_cnt", 32'(tok_cnt), 32'(exp_tok));

        // Long run crossing MAX
        do_reset();
        check("long_done_before", 32'(done), 32'd0);
        for (int i = 0; i < 300; i++) row_buf[i] = 4;
        send_row(300, 1, 0);
        drain();
        check("long_done", 32'(done), 32'd1);
        check("long_in_ready", 32'(bus.in_ready), 32'd0);
        check("long_tok_cnt", 32'(tok_cnt), 32'd2);

        // Random 64x4 frame with random valid gaps and ready toggling
        do_reset();
        rdy_mode = 1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) row_buf[i] = 8'($urandom_range(0, 2));
            send_row(64, r == 3, 1);
        end
        drain();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        check("rand_done", 32'(done), 32'd1);
        check("rand_tok_cnt", 32'(tok_cnt), 32'(exp_tok));

        // Reset in the middle of an open run of three
        do_reset();
        row_buf[0] = 2;
        send_row(1, 0, 0);
        exp_q.push_back(make_tok(1'b0, 1'b0, CNT_W'(1), 8'd7));
        exp_tok++;
        send_pixel(8'd7, 0, 0, 0);
        send_pixel(8'd9, 0, 0, 0);
        send_pixel(8'd9, 0, 0, 0);
        send_pixel(8'd9, 0, 0, 0);
        drain();
        check("mid_tok_cnt", 32'(tok_cnt), 32'd2);
        #3;
        rst = 1'b0;
        exp_q.delete();
        exp_tok = 0;
        #1;
        check("async_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_out_fields", {13'd0, bus.out_eof, bus.out_eor, bus.out_count, bus.out_value}, 32'd0);
        check("async_tok_cnt", 32'(tok_cnt), 32'd0);
        check("async_done", 32'(done), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) row_buf[i] = 8'($urandom_range(0, 1));
            send_row(8, r == 2, 0);
        end
        drain();
        check("post_rst_done", 32'(done), 32'd1);
        check("post_rst_tok_cnt", 32'(tok_cnt), 32'(exp_tok));
        check("post_rst_queue", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
